if_id_skid_stage: RTL and testbench
===================================

// Module: if_id_skid_stage
// PURPOSE
// - Parametrised IF/ID pipeline register with valid/ready handshakes on both sides.
// - Adds a 2-entry skid buffer so up_ready_o is a pure register output (no comb path from dn_ready_i).
// - Hazard stall (hz_i) and branch flush (flush_i) are handled in-stage.
// - Saturating stall/flush event counters are exposed for performance debug.
// PARAMETERS
// - PC_W    32            width of the PC field
// - INST_W  32            width of the instruction field
// - NOP_INST 32'h00000013 bubble instruction on inst_o whenever the stage holds no valid beat
// - CNT_W   16            width of each saturating performance counter
// PORTS
// - clk_i        in   1       clock, rising edge
// - rst_i        in   1       asynchronous reset, active-high
// - up_valid_i   in   1       IF presents a beat
// - up_ready_o   out  1       stage accepts a beat this cycle
// - pc_i         in   PC_W    fetched PC
// - inst_i       in   INST_W  fetched instruction
// - hz_i         in   1       hazard stall from ID: hold the output beat
// - flush_i      in   1       discard all held beats (taken branch/jump)
// - dn_valid_o   out  1       ID beat valid
// - dn_ready_i   in   1       ID consumes the beat
// - pc_o         out  PC_W    PC of the output beat
// - inst_o       out  INST_W  instruction of the output beat; NOP_INST when dn_valid_o=0
// - stall_cnt_o  out  CNT_W   cycles with dn_valid_o=1 and the beat not consumed
// - flush_cnt_o  out  CNT_W   cycles with flush_i=1 while at least one beat is held
// BEHAVIOUR
// - Internal storage: main {m_vld,m_pc,m_inst} drives the outputs; skid {s_vld,s_pc,s_inst} is backup.
// - States: EMPTY (m_vld=0), ONE (m_vld=1,s_vld=0), TWO (m_vld=1,s_vld=1). s_vld=1 implies m_vld=1.
// - Definitions: acc = up_valid_i & up_ready_o; take = m_vld & dn_ready_i & ~hz_i.
// - up_ready_o = ~s_vld. Registered state only; never combinationally depends on dn_ready_i or hz_i.
// - dn_valid_o = m_vld; pc_o = m_pc; inst_o = m_vld ? m_inst : NOP_INST.
// - Transitions when flush_i=0:
//   - EMPTY: acc -> ONE, with the beat loaded into main.
//   - ONE: acc & take -> ONE, main reloaded. acc & ~take -> TWO, beat into skid.
//     ~acc & take -> EMPTY.
//   - TWO: take -> ONE, skid moves to main. No accept is possible in TWO.
// - Latency: one cycle from acc to dn_valid_o; throughput one beat per cycle in steady ONE state.
// - hz_i=1 blocks take regardless of dn_ready_i. Upstream may still fill the skid entry (ONE -> TWO).
// - flush_i=1, highest priority, over hz_i and all handshakes:
//   - Next state is EMPTY; m_vld and s_vld are cleared.
//   - A beat accepted in the same cycle (acc=1) is dropped.
//   - pc regs keep their old value; inst_o shows NOP_INST from the next cycle.
// - Beat ordering is strictly FIFO. No beat is ever duplicated or lost except by flush.
// - Counters:
//   - stall_cnt_o increments when m_vld & ~take & ~flush_i.
//   - flush_cnt_o increments when flush_i & m_vld.
//   - Both saturate at all-ones; they are not cleared by flush_i.
// - Reset (async, any cycle including mid-transfer):
//   - State EMPTY: m_vld=s_vld=0, so dn_valid_o=0, up_ready_o=1.
//   - m_pc=s_pc=0, m_inst=s_inst=NOP_INST, so pc_o=0 and inst_o=NOP_INST.
//   - Both counters are 0.
// - Data registers load only on a state-relevant write; no X propagation from inputs while valid=0.
// STRUCTURE
// - Shared package pipe_pkg: NOP_INST constant; state enum {ST_EMPTY, ST_ONE, ST_TWO}; default widths.
// - Sub-module sat_counter #(W): clk_i, rst_i, inc_i, cnt_o. Instantiated twice (stall, flush).
// - Top: state register, main/skid data registers, output mux. No other hierarchy.
// TESTING
// - Reset mid-stream: beat 0x100/0x00A00093 accepted, rst_i pulsed asynchronously.
//   -> dn_valid_o=0, inst_o=0x13, pc_o=0, up_ready_o=1 with no clock edge.
// - Streaming: 8 beats, pc 0x0..0x1C, dn_ready_i=1, hz_i=0.
//   -> outputs arrive in order, 1-cycle latency, up_ready_o stays 1, stall_cnt_o=0.
// - Backpressure: dn_ready_i=0 for 3 cycles during streaming.
//   -> up_ready_o drops after 2 beats are held, no loss or duplication, stall_cnt_o=3.
// - Hazard: hz_i=1 with dn_ready_i=1 for 2 cycles on beat pc=0x8.
//   -> pc_o=0x8 held, inst_o unchanged, skid fills with pc=0xC, order preserved afterwards.
// - Flush in TWO with up_valid_i=1 in the same cycle.
//   -> next cycle dn_valid_o=0, inst_o=0x13, the incoming beat is dropped, flush_cnt_o +1.
// - Saturation: CNT_W=4, hold a stall for 20 cycles -> stall_cnt_o=4'hF and stays there.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared constants and the occupancy state type for the IF/ID skid stage.
package pipe_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  // Canonical RISC-V bubble: addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; cleared only by reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
  end

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a 2-entry skid so up_ready_o is purely registered.
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned        PC_W     = PC_W_DEF,
  parameter int unsigned        INST_W   = INST_W_DEF,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(pipe_pkg::NOP_INST),
  parameter int unsigned        CNT_W    = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              hz_i,
  input  logic              flush_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  skid_state_e       state_q, state_d;
  logic [PC_W-1:0]   m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [INST_W-1:0] m_inst_q, m_inst_d, s_inst_q, s_inst_d;
  logic              m_vld, s_vld, acc, take;

  assign m_vld      = (state_q != ST_EMPTY);
  assign s_vld      = (state_q == ST_TWO);
  assign up_ready_o = ~s_vld;
  assign acc        = up_valid_i & up_ready_o;
  assign take       = m_vld & dn_ready_i & ~hz_i;

  always_comb begin
    state_d  = state_q;
    m_pc_d   = m_pc_q;
    m_inst_d = m_inst_q;
    s_pc_d   = s_pc_q;
    s_inst_d = s_inst_q;
    if (flush_i) begin
      // Data registers keep stale contents; only the valid state is dropped.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d  = ST_ONE;
            m_pc_d   = pc_i;
            m_inst_d = inst_i;
          end
        end
        ST_ONE: begin
          if (acc && take) begin
            m_pc_d   = pc_i;
            m_inst_d = inst_i;
          end else if (acc) begin
            state_d  = ST_TWO;
            s_pc_d   = pc_i;
            s_inst_d = inst_i;
          end else if (take) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (take) begin
            state_d  = ST_ONE;
            m_pc_d   = s_pc_q;
            m_inst_d = s_inst_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // NOTE: the two data entries are reset too, so pc_o/inst_o are defined immediately after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_EMPTY;
      m_pc_q   <= '0;
      m_inst_q <= NOP_INST;
      s_pc_q   <= '0;
      s_inst_q <= NOP_INST;
    end else begin
      state_q  <= state_d;
      m_pc_q   <= m_pc_d;
      m_inst_q <= m_inst_d;
      s_pc_q   <= s_pc_d;
      s_inst_q <= s_inst_d;
    end
  end

  assign dn_valid_o = m_vld;
  assign pc_o       = m_pc_q;
  assign inst_o     = m_vld ? m_inst_q : NOP_INST;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (m_vld & ~take & ~flush_i),
    .cnt_o (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_i & m_vld),
    .cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Randomized and directed bench for if_id_skid_stage against a queue-based occupancy model.
module tb_if_id_skid_stage;

  localparam int          PC_W   = 32;
  localparam int          INST_W = 32;
  localparam int          CNT_W  = 4;
  localparam int unsigned SAT    = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              up_valid_i = 1'b0;
  logic              up_ready_o;
  logic [PC_W-1:0]   pc_i = '0;
  logic [INST_W-1:0] inst_i = '0;
  logic              hz_i = 1'b0;
  logic              flush_i = 1'b0;
  logic              dn_valid_o;
  logic              dn_ready_i = 1'b0;
  logic [PC_W-1:0]   pc_o;
  logic [INST_W-1:0] inst_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  if_id_skid_stage #(
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .up_valid_i  (up_valid_i),
    .up_ready_o  (up_ready_o),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .hz_i        (hz_i),
    .flush_i     (flush_i),
    .dn_valid_o  (dn_valid_o),
    .dn_ready_i  (dn_ready_i),
    .pc_o        (pc_o),
    .inst_o      (inst_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } beat_t;

  // Model: the stage is a FIFO of at most two beats plus two saturating counters.
  beat_t       mq[$];
  int unsigned m_stall, m_flush;
  bit          mon_hv, mon_tk, mon_ac;

  int          n_chk = 0;
  int          n_err = 0;

  logic [31:0] cur_pc, cur_inst, last_pc;
  logic [31:0] sent_inst[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares outputs at the falling edge, then advances the model through the coming rising edge.
  always @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mq.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      mon_hv = (mq.size() != 0);
      check("dn_valid", 32'(dn_valid_o), 32'(mon_hv));
      check("up_ready", 32'(up_ready_o), 32'(mq.size() < 2));
      if (mon_hv) begin
        check("pc_o", pc_o, mq[0].pc);
        check("inst_o", inst_o, mq[0].inst);
      end else begin
        check("inst_nop", inst_o, NOP);
      end
      check("stall_cnt", 32'(stall_cnt_o), m_stall);
      check("flush_cnt", 32'(flush_cnt_o), m_flush);

      mon_tk = mon_hv && dn_ready_i && !hz_i;
      mon_ac = up_valid_i && (mq.size() < 2);
      if (flush_i) begin
        if (mon_hv && m_flush < SAT) m_flush++;
        mq.delete();
      end else begin
        if (mon_hv && !mon_tk && m_stall < SAT) m_stall++;
        if (mon_tk) void'(mq.pop_front());
        if (mon_ac) mq.push_back(beat_t'{pc: pc_i, inst: inst_i});
      end
    end
  end

  // One cycle of stimulus, driven at posedge+1; the current beat advances once accepted.
  task automatic step(input bit v, input bit dr, input bit hz, input bit fl);
    bit sent;
    up_valid_i = v;
    pc_i       = cur_pc;
    inst_i     = cur_inst;
    dn_ready_i = dr;
    hz_i       = hz;
    flush_i    = fl;
    sent       = v && up_ready_o;
    @(posedge clk_i);
    #1;
    if (sent) begin
      sent_inst.push_back(cur_inst);
      last_pc  = cur_pc;
      cur_pc   = cur_pc + 32'd4;
      cur_inst = $urandom;
    end
  endtask

  task automatic pulse_reset();
    up_valid_i = 1'b0;
    dn_ready_i = 1'b0;
    hz_i       = 1'b0;
    flush_i    = 1'b0;
    #1 rst_i = 1'b1;
    #1 rst_i = 1'b0;
    sent_inst.delete();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    cur_pc   = '0;
    cur_inst = $urandom;
    last_pc  = '0;

    // Power-on reset, checked without any clock edge.
    #1 rst_i = 1'b1;
    #1;
    check("rst_dn_valid", 32'(dn_valid_o), 32'd0);
    check("rst_up_ready", 32'(up_ready_o), 32'd1);
    check("rst_pc", pc_o, 32'd0);
    check("rst_inst", inst_o, NOP);
    check("rst_cnts", 32'({stall_cnt_o, flush_cnt_o}), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Asynchronous reset with a beat held in the stage.
    cur_pc   = 32'h100;
    cur_inst = 32'h00A0_0093;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    up_valid_i = 1'b0;
    check("mid_valid", 32'(dn_valid_o), 32'd1);
    check("mid_pc", pc_o, 32'h100);
    #1 rst_i = 1'b1;
    #1;
    check("arst_dn_valid", 32'(dn_valid_o), 32'd0);
    check("arst_inst", inst_o, NOP);
    check("arst_pc", pc_o, 32'd0);
    check("arst_up_ready", 32'(up_ready_o), 32'd1);
    #1 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Streaming: each beat appears one cycle after acceptance.
    pulse_reset();
    cur_pc = '0;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("stream_pc", pc_o, 32'(i * 4));
      check("stream_ready", 32'(up_ready_o), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("stream_stall", 32'(stall_cnt_o), 32'd0);

    // Backpressure: downstream not ready for three cycles.
    pulse_reset();
    cur_pc = '0;
    for (int c = 0; c < 14; c++) begin
      step(cur_pc < 32'd32, !(c >= 2 && c <= 4), 1'b0, 1'b0);
      if (c == 2) check("bp_ready_low", 32'(up_ready_o), 32'd0);
    end
    check("bp_stall", 32'(stall_cnt_o), 32'd3);
    check("bp_drained", 32'(dn_valid_o), 32'd0);
    check("bp_sent", 32'(sent_inst.size()), 32'd8);

    // Hazard: hold beat pc=0x8 for two cycles while the skid fills.
    pulse_reset();
    cur_pc = '0;
    for (int c = 0; c < 12; c++) begin
      step(cur_pc < 32'd24, 1'b1, (c == 3 || c == 4), 1'b0);
      if (c == 3 || c == 4) begin
        check("hz_pc", pc_o, 32'h8);
        check("hz_inst", inst_o, sent_inst[2]);
        check("hz_ready", 32'(up_ready_o), 32'd0);
      end
    end
    check("hz_stall", 32'(stall_cnt_o), 32'd2);

    // Flush in TWO with an incoming beat, then in ONE with a real accept.
    pulse_reset();
    cur_pc = 32'h40;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fl_two_ready", 32'(up_ready_o), 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("fl_two_valid", 32'(dn_valid_o), 32'd0);
    check("fl_two_inst", inst_o, NOP);
    check("fl_two_cnt", 32'(flush_cnt_o), 32'd1);
    check("fl_two_stall", 32'(stall_cnt_o), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    check("fl_one_valid", 32'(dn_valid_o), 32'd0);
    check("fl_one_cnt", 32'(flush_cnt_o), 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("fl_empty_cnt", 32'(flush_cnt_o), 32'd2);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("fl_resume_pc", pc_o, last_pc);

    // Saturation of the stall counter.
    pulse_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_stall", 32'(stall_cnt_o), SAT);
    repeat (5) step(1'b0, 1'b1, 1'b1, 1'b0);
    check("sat_hold", 32'(stall_cnt_o), SAT);

    // Random traffic; the monitor checks every cycle.
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 2, $urandom_range(0, 19) == 0);
    end
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b0);
    check("rand_drained", 32'(dn_valid_o), 32'd0);

    @(posedge clk_i);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
